// File: rtl/calculadora_secuenciador.sv
// rtl/calculadora_secuenciador.sv - keypad-side command sequencer for the calculator core
//
// Builds a 16-bit operand from decimal digit keys (binary or BCD entry),
// latches an operation code, and on enter issues a one-cycle start to the
// core, then waits for ready. A timeout bounds the wait.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   key_valid, key_code keypad strobe and 5-bit key code
//   core_ready          level ready from the core (honoured only in WAIT)
//   core_result         32-bit result from the core
//   operand_a           operand register driven to the core
//   operation           operation code register driven to the core
//   start               one-cycle start pulse (ISSUE state)
//   result_q            captured core result
//   result_valid        result_q holds a fresh result
//   busy                command in flight (ISSUE or WAIT)
//   overflow            sticky: a digit was rejected
//   timeout_err         sticky: last command timed out
module calculadora_secuenciador #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic        core_ready,
    input  logic [31:0] core_result,
    output logic [15:0] operand_a,
    output logic [2:0]  operation,
    output logic        start,
    output logic [31:0] result_q,
    output logic        result_valid,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [4:0]  KEY_OP_FIRST = 5'h10;
    localparam logic [4:0]  KEY_OP_LAST  = 5'h14;
    localparam logic [4:0]  KEY_ENTER    = 5'h1E;
    localparam logic [4:0]  KEY_CLEAR    = 5'h1F;
    localparam logic [2:0]  OP_BCD       = 3'b100;
    localparam logic [15:0] CNT_LAST     = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;

    // Key decode; codes outside the listed ranges decode to nothing.
    logic is_digit;
    logic is_op;
    logic is_enter;
    logic is_clear;

    always_comb begin
        is_digit = key_valid && (key_code <= 5'd9);
        is_op    = key_valid && (key_code >= KEY_OP_FIRST) && (key_code <= KEY_OP_LAST);
        is_enter = key_valid && (key_code == KEY_ENTER);
        is_clear = key_valid && (key_code == KEY_CLEAR);
    end

    // Digit accumulation candidates. The binary product is formed in 20 bits
    // so that any value above 65535 is visible in the top nibble.
    logic [19:0] bin_next;
    logic        bin_fits;
    logic        bcd_fits;
    logic        bcd_mode;
    logic        wait_expired;

    always_comb begin
        bin_next     = 20'(operand_a) * 20'd10 + 20'(key_code[3:0]);
        bin_fits     = (bin_next[19:16] == 4'd0);
        bcd_fits     = (operand_a[15:12] == 4'd0);
        bcd_mode     = (operation == OP_BCD);
        wait_expired = (wait_cnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Clear outranks ready, and ready outranks expiry.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (is_enter && !overflow) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_clear) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (is_clear || core_ready || wait_expired) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the state register, so an asynchronous
    // reset removes start and busy immediately with no extra register stage.
    always_comb begin
        start = (state == S_ISSUE);
        busy  = (state != S_IDLE);
    end

    // Wait counter: zeroed while issuing, counts each WAIT cycle without ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 16'd0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= 16'd0;
        end else if (state == S_WAIT && !core_ready && !wait_expired) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Operand, operation and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_a    <= 16'd0;
            operation    <= 3'd0;
            result_q     <= 32'd0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (is_clear) begin
            // Clear is accepted in every state; in ISSUE/WAIT it also aborts
            // the command, so a simultaneous ready is dropped.
            operand_a    <= 16'd0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        if (bcd_mode) begin
                            if (bcd_fits) begin
                                operand_a <= {operand_a[11:0], key_code[3:0]};
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            if (bin_fits) begin
                                operand_a <= bin_next[15:0];
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end else if (is_op) begin
                        operation <= key_code[2:0];
                    end else if (is_enter && !overflow) begin
                        result_valid <= 1'b0;
                        timeout_err  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (core_ready) begin
                        result_q     <= core_result;
                        result_valid <= 1'b1;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
